// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-memory responder: word RAM, lane-masked stores, extended loads
// IDLE -> WAIT (WAIT_STATES cycles) -> RESP; one-cycle ready pulse with registered rdata.
module data_mem_responder #(
   parameter int DEPTH       = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_en,
   input  logic        req_rw,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  st_cmd,
   input  logic [2:0]  ld_cmd,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        busy,
   output logic        misaligned
);
   localparam int         AW      = $clog2(DEPTH);
   localparam logic [3:0] WS      = WAIT_STATES[3:0];
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_RESP  = 2'd2;
   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   logic [1:0]  r_state;
   logic [3:0]  r_cnt;
   logic        r_rw;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [2:0]  r_st_cmd;
   logic [2:0]  r_ld_cmd;
   logic [31:0] r_rdata;
   logic        r_misaligned;
   logic [31:0] r_mem [DEPTH];

   logic          w_enter_resp;
   logic          w_rw;
   logic          w_misal;
   logic [31:0]   w_addr;
   logic [31:0]   w_wdata;
   logic [2:0]    w_st;
   logic [2:0]    w_ld;
   logic [1:0]    w_size;
   logic [AW-1:0] w_idx;
   logic [31:0]   w_word;
   logic [31:0]   w_load;
   logic [31:0]   w_lane_data;
   logic [3:0]    w_lane_mask;
   logic [7:0]    w_byte;
   logic [15:0]   w_half;
   logic          w_unused;

   // With no wait states the access completes on the accept edge, so the op comes from the inputs.
   assign w_rw    = (r_state == S_IDLE) ? req_rw    : r_rw;
   assign w_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
   assign w_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
   assign w_st    = (r_state == S_IDLE) ? st_cmd    : r_st_cmd;
   assign w_ld    = (r_state == S_IDLE) ? ld_cmd    : r_ld_cmd;

   assign w_enter_resp = ((r_state == S_IDLE) && req_en && (WS == 4'd0)) ||
                         ((r_state == S_WAIT) && ((r_cnt + 4'd1) == WS));

   always_comb begin
      w_size = SZ_WORD;
      if (w_rw) begin
         case (w_st)
            3'b011:  w_size = SZ_BYTE;
            3'b100:  w_size = SZ_HALF;
            default: w_size = SZ_WORD;
         endcase
      end else begin
         case (w_ld)
            3'b001, 3'b011: w_size = SZ_BYTE;
            3'b010, 3'b100: w_size = SZ_HALF;
            default:        w_size = SZ_WORD;
         endcase
      end
   end

   assign w_misal  = ((w_size == SZ_HALF) && w_addr[0]) ||
                     ((w_size == SZ_WORD) && (w_addr[1:0] != 2'b00));
   assign w_idx    = w_addr[AW+1:2];
   assign w_unused = ^w_addr[31:AW+2];
   assign w_word   = r_mem[w_idx];
   assign w_byte   = w_word[{w_addr[1:0], 3'b000} +: 8];
   assign w_half   = w_addr[1] ? w_word[31:16] : w_word[15:0];

   always_comb begin
      w_load = w_word;
      case (w_ld)
         3'b001:  w_load = {24'd0, w_byte};
         3'b010:  w_load = {16'd0, w_half};
         3'b011:  w_load = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_load = {{16{w_half[15]}}, w_half};
         default: w_load = w_word;
      endcase
   end

   always_comb begin
      w_lane_mask = 4'b1111;
      w_lane_data = w_wdata;
      case (w_size)
         SZ_BYTE: begin
            w_lane_mask = 4'b0001 << w_addr[1:0];
            w_lane_data = {4{w_wdata[7:0]}};
         end
         SZ_HALF: begin
            w_lane_mask = w_addr[1] ? 4'b1100 : 4'b0011;
            w_lane_data = {2{w_wdata[15:0]}};
         end
         default: begin
            w_lane_mask = 4'b1111;
            w_lane_data = w_wdata;
         end
      endcase
   end

   // RAM contents survive reset; only the write enable is gated by it.
   always_ff @(posedge clk) begin
      if (!rst && w_enter_resp && w_rw && !w_misal) begin
         if (w_lane_mask[0]) r_mem[w_idx][7:0]   <= w_lane_data[7:0];
         if (w_lane_mask[1]) r_mem[w_idx][15:8]  <= w_lane_data[15:8];
         if (w_lane_mask[2]) r_mem[w_idx][23:16] <= w_lane_data[23:16];
         if (w_lane_mask[3]) r_mem[w_idx][31:24] <= w_lane_data[31:24];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= 4'd0;
         r_rw         <= 1'b0;
         r_addr       <= 32'd0;
         r_wdata      <= 32'd0;
         r_st_cmd     <= 3'd0;
         r_ld_cmd     <= 3'd0;
         r_rdata      <= 32'd0;
         r_misaligned <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_cnt <= 4'd0;
               if (req_en) begin
                  r_rw     <= req_rw;
                  r_addr   <= req_addr;
                  r_wdata  <= req_wdata;
                  r_st_cmd <= st_cmd;
                  r_ld_cmd <= ld_cmd;
                  r_state  <= (WS == 4'd0) ? S_RESP : S_WAIT;
               end
            end
            S_WAIT: begin
               r_cnt <= r_cnt + 4'd1;
               if ((r_cnt + 4'd1) == WS) r_state <= S_RESP;
            end
            S_RESP: begin
               r_cnt   <= 4'd0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
         if (w_enter_resp) begin
            r_misaligned <= w_misal;
            r_rdata      <= (w_rw || w_misal) ? 32'd0 : w_load;
         end
      end
   end

   assign rdata      = r_rdata;
   assign ready      = (r_state == S_RESP);
   assign busy       = (r_state != S_IDLE);
   assign misaligned = (r_state == S_RESP) && r_misaligned;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - bench for data_mem_responder with WAIT_STATES=0 and 3 instances
// A byte-level memory model predicts every output each cycle; directed literals pin the model.
`timescale 1ns/1ps
module tb_data_mem_responder;
   localparam int DEPTH = 1024;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst       [2];
   logic        req_en    [2];
   logic        req_rw    [2];
   logic [31:0] req_addr  [2];
   logic [31:0] req_wdata [2];
   logic [2:0]  st_cmd    [2];
   logic [2:0]  ld_cmd    [2];
   logic [31:0] rdata     [2];
   logic        ready     [2];
   logic        busy      [2];
   logic        misaligned[2];

   data_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
      .clk(clk), .rst(rst[0]), .req_en(req_en[0]), .req_rw(req_rw[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .st_cmd(st_cmd[0]),
      .ld_cmd(ld_cmd[0]), .rdata(rdata[0]), .ready(ready[0]), .busy(busy[0]),
      .misaligned(misaligned[0]));

   data_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(3)) u_ws3 (
      .clk(clk), .rst(rst[1]), .req_en(req_en[1]), .req_rw(req_rw[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .st_cmd(st_cmd[1]),
      .ld_cmd(ld_cmd[1]), .rdata(rdata[1]), .ready(ready[1]), .busy(busy[1]),
      .misaligned(misaligned[1]));

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   bit chk_en = 1'b0;

   int          m_lo   [2];
   int          m_hi   [2];
   bit          m_pend [2];
   bit          o_rw   [2];
   logic [31:0] o_addr [2];
   logic [31:0] o_wdata[2];
   logic [2:0]  o_st   [2];
   logic [2:0]  o_ld   [2];
   logic [31:0] e_rdata[2];
   bit          e_mis  [2];
   logic [7:0]  m_mem  [int];

   function automatic int ws(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   function automatic int key(input int d, input logic [31:0] a);
      return (d << 16) | int'(a & 32'(DEPTH * 4 - 1));
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic apply(input int d);
      int          size;
      int          k;
      logic [31:0] v;
      if (o_rw[d])
         size = (o_st[d] == 3'b011) ? 1 : (o_st[d] == 3'b100) ? 2 : 4;
      else
         size = (o_ld[d] == 3'b001 || o_ld[d] == 3'b011) ? 1 :
                (o_ld[d] == 3'b010 || o_ld[d] == 3'b100) ? 2 : 4;
      e_mis[d]   = (int'(o_addr[d][1:0]) % size) != 0;
      e_rdata[d] = 32'h0;
      if (!e_mis[d]) begin
         if (o_rw[d]) begin
            for (int i = 0; i < size; i++) m_mem[key(d, o_addr[d] + 32'(i))] = o_wdata[d][8*i +: 8];
         end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) begin
               k = key(d, o_addr[d] + 32'(i));
               v[8*i +: 8] = m_mem.exists(k) ? m_mem[k] : 8'h00;
            end
            if (o_ld[d] == 3'b011) v = {{24{v[7]}}, v[7:0]};
            if (o_ld[d] == 3'b100) v = {{16{v[15]}}, v[15:0]};
            e_rdata[d] = v;
         end
      end
   endtask

   // Model: a request is taken when the previous interval was idle; it completes WAIT_STATES edges later.
   initial begin
      for (int d = 0; d < 2; d++) begin
         m_lo[d] = 0; m_hi[d] = -1; m_pend[d] = 1'b0; e_rdata[d] = 32'h0; e_mis[d] = 1'b0;
      end
      forever begin
         @(posedge clk);
         cyc++;
         for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
               m_pend[d] = 1'b0; m_lo[d] = cyc; m_hi[d] = cyc - 1;
               e_rdata[d] = 32'h0; e_mis[d] = 1'b0;
            end else begin
               if (req_en[d] && (cyc - 1) > m_hi[d]) begin
                  m_lo[d] = cyc; m_hi[d] = cyc + ws(d); m_pend[d] = 1'b1;
                  o_rw[d] = req_rw[d]; o_addr[d] = req_addr[d]; o_wdata[d] = req_wdata[d];
                  o_st[d] = st_cmd[d]; o_ld[d] = ld_cmd[d];
               end
               if (m_pend[d] && cyc == m_hi[d]) begin
                  apply(d);
                  m_pend[d] = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      bit exp_rdy;
      bit exp_busy;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
               exp_rdy  = (cyc == m_hi[d]);
               exp_busy = (cyc >= m_lo[d]) && (cyc <= m_hi[d]);
               chk($sformatf("ready%0d", d), {31'd0, ready[d]}, {31'd0, exp_rdy});
               chk($sformatf("busy%0d", d), {31'd0, busy[d]}, {31'd0, exp_busy});
               chk($sformatf("misaligned%0d", d), {31'd0, misaligned[d]}, {31'd0, exp_rdy & e_mis[d]});
               chk($sformatf("rdata%0d", d), rdata[d], e_rdata[d]);
            end
         end
      end
   end

   task automatic do_req(input int d, input bit rw, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] st, input logic [2:0] ld);
      int n;
      @(negedge clk);
      req_en[d] = 1'b1; req_rw[d] = rw; req_addr[d] = a; req_wdata[d] = wd;
      st_cmd[d] = st; ld_cmd[d] = ld;
      @(negedge clk);
      req_en[d] = 1'b0;
      n = 0;
      while (!ready[d] && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("ready_seen%0d", d), {31'd0, ready[d]}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      int          nrdy;
      int          rdy_at;
      logic [31:0] rd_hit;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; req_en[d] = 1'b0; req_rw[d] = 1'b0; req_addr[d] = 32'h0;
         req_wdata[d] = 32'h0; st_cmd[d] = 3'd0; ld_cmd[d] = 3'd0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst[0] = 1'b0; rst[1] = 1'b0;
      chk_en = 1'b1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_rdata%0d", d), rdata[d], 32'h0);
         chk($sformatf("rst_busy%0d", d), {31'd0, busy[d]}, 32'd0);
         chk($sformatf("rst_ready%0d", d), {31'd0, ready[d]}, 32'd0);
      end

      do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b000, 3'b000);
      do_req(0, 1'b0, 32'h10, 32'h0, 3'b000, 3'b000);
      chk("lw_10", rdata[0], 32'hDEADBEEF);
      chk("lw_10_mis", {31'd0, misaligned[0]}, 32'd0);

      do_req(0, 1'b1, 32'h10, 32'h11223344, 3'b000, 3'b000);
      do_req(0, 1'b1, 32'h13, 32'h12345680, 3'b011, 3'b000);
      do_req(0, 1'b0, 32'h13, 32'h0, 3'b000, 3'b011);
      chk("lb_13", rdata[0], 32'hFFFFFF80);
      do_req(0, 1'b0, 32'h13, 32'h0, 3'b000, 3'b001);
      chk("lbu_13", rdata[0], 32'h00000080);
      do_req(0, 1'b0, 32'h10, 32'h0, 3'b000, 3'b000);
      chk("lw_after_sb", rdata[0], 32'h80223344);

      do_req(0, 1'b1, 32'h20, 32'h0000AAAA, 3'b000, 3'b000);
      do_req(0, 1'b1, 32'h22, 32'hFFFF8001, 3'b100, 3'b000);
      do_req(0, 1'b0, 32'h22, 32'h0, 3'b000, 3'b100);
      chk("lh_22", rdata[0], 32'hFFFF8001);
      do_req(0, 1'b0, 32'h22, 32'h0, 3'b000, 3'b010);
      chk("lhu_22", rdata[0], 32'h00008001);
      do_req(0, 1'b0, 32'h20, 32'h0, 3'b000, 3'b000);
      chk("lw_after_sh", rdata[0], 32'h8001AAAA);

      do_req(0, 1'b1, 32'h12, 32'h55555555, 3'b000, 3'b000);
      chk("sw_12_mis", {31'd0, misaligned[0]}, 32'd1);
      do_req(0, 1'b0, 32'h01, 32'h0, 3'b000, 3'b100);
      chk("lh_01_mis", {31'd0, misaligned[0]}, 32'd1);
      chk("lh_01_rdata", rdata[0], 32'h0);
      do_req(0, 1'b0, 32'h10, 32'h0, 3'b000, 3'b000);
      chk("lw_10_unchanged", rdata[0], 32'h80223344);

      do_req(0, 1'b1, 32'h1000, 32'hCAFEF00D, 3'b000, 3'b000);
      do_req(0, 1'b0, 32'h0, 32'h0, 3'b000, 3'b000);
      chk("wrap_lw_0", rdata[0], 32'hCAFEF00D);
      do_req(0, 1'b0, 32'h1010, 32'h0, 3'b000, 3'b000);
      chk("wrap_lw_1010", rdata[0], 32'h80223344);

      do_req(1, 1'b1, 32'h40, 32'h11111111, 3'b000, 3'b000);
      @(negedge clk);
      req_en[1] = 1'b1; req_rw[1] = 1'b0; req_addr[1] = 32'h40; ld_cmd[1] = 3'b000;
      nrdy = 0; rdy_at = -1; rd_hit = 32'h0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         if (i == 4) req_en[1] = 1'b0;
         if (ready[1]) begin
            nrdy++;
            rdy_at = i;
            rd_hit = rdata[1];
         end
      end
      chk("ws3_one_ready", 32'(nrdy), 32'd1);
      chk("ws3_latency", 32'(rdy_at), 32'd3);
      chk("ws3_lw_40", rd_hit, 32'h11111111);

      @(negedge clk);
      req_en[1] = 1'b1; req_rw[1] = 1'b1; req_addr[1] = 32'h40; req_wdata[1] = 32'h22222222;
      st_cmd[1] = 3'b000;
      @(negedge clk);
      req_en[1] = 1'b0;
      @(negedge clk);
      rst[1] = 1'b1;
      @(negedge clk);
      rst[1] = 1'b0;
      chk("rst_mid_wait_busy", {31'd0, busy[1]}, 32'd0);
      repeat (5) @(negedge clk);
      rst[1] = 1'b1; req_en[1] = 1'b1; req_rw[1] = 1'b0;
      @(negedge clk);
      rst[1] = 1'b0; req_en[1] = 1'b0;
      chk("rst_and_req_busy", {31'd0, busy[1]}, 32'd0);
      repeat (5) @(negedge clk);
      do_req(1, 1'b0, 32'h40, 32'h0, 3'b000, 3'b000);
      chk("rst_write_discarded", rdata[1], 32'h11111111);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
